// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous memory port between an instruction-fetch
// master (m0, reads only) and a load/store master (m1, reads and byte-masked writes).
// Requests are latched, arbitrated round-robin and sequenced one access at a time.
// Optional build macro MEM_ARB_FIXED_PRIO_EN: when defined, master 1 always wins ties.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic                m0_rstrb,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic                m0_rbusy,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic                m1_rstrb,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wmask,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                m1_rbusy,
    output logic                m1_wbusy,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_rstrb,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int unsigned MASK_W = DATA_W / 8;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

    state_t              r_state,     w_state_n;
    logic [CNT_W-1:0]    r_cnt,       w_cnt_n;
    logic                r_gnt,       w_gnt_n;
    logic                r_last,      w_last_n;
    logic                r_req0,      w_req0_n;
    logic                r_req1,      w_req1_n;
    logic                r_p1_wr,     w_p1_wr_n;
    logic [ADDR_W-1:0]   r_p0_addr,   w_p0_addr_n;
    logic [ADDR_W-1:0]   r_p1_addr,   w_p1_addr_n;
    logic [DATA_W-1:0]   r_p1_wdata,  w_p1_wdata_n;
    logic [MASK_W-1:0]   r_p1_wmask,  w_p1_wmask_n;
    logic [DATA_W-1:0]   r_m0_rdata,  w_m0_rdata_n;
    logic [DATA_W-1:0]   r_m1_rdata,  w_m1_rdata_n;
    logic                r_m0_rbusy,  w_m0_rbusy_n;
    logic                r_m1_rbusy,  w_m1_rbusy_n;
    logic                r_m1_wbusy,  w_m1_wbusy_n;
    logic [ADDR_W-1:0]   r_mem_addr,  w_mem_addr_n;
    logic                r_mem_rstrb, w_mem_rstrb_n;
    logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata_n;
    logic [MASK_W-1:0]   r_mem_wmask, w_mem_wmask_n;
    logic                w_acc0, w_acc1r, w_acc1w, w_free, w_sel1;

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_gnt       <= 1'b0;
            r_last      <= 1'b1;
            r_req0      <= 1'b0;
            r_req1      <= 1'b0;
            r_p1_wr     <= 1'b0;
            r_p0_addr   <= '0;
            r_p1_addr   <= '0;
            r_p1_wdata  <= '0;
            r_p1_wmask  <= '0;
            r_m0_rdata  <= '0;
            r_m1_rdata  <= '0;
            r_m0_rbusy  <= 1'b0;
            r_m1_rbusy  <= 1'b0;
            r_m1_wbusy  <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_rstrb <= 1'b0;
            r_mem_wdata <= '0;
            r_mem_wmask <= '0;
        end else begin
            r_state     <= w_state_n;
            r_cnt       <= w_cnt_n;
            r_gnt       <= w_gnt_n;
            r_last      <= w_last_n;
            r_req0      <= w_req0_n;
            r_req1      <= w_req1_n;
            r_p1_wr     <= w_p1_wr_n;
            r_p0_addr   <= w_p0_addr_n;
            r_p1_addr   <= w_p1_addr_n;
            r_p1_wdata  <= w_p1_wdata_n;
            r_p1_wmask  <= w_p1_wmask_n;
            r_m0_rdata  <= w_m0_rdata_n;
            r_m1_rdata  <= w_m1_rdata_n;
            r_m0_rbusy  <= w_m0_rbusy_n;
            r_m1_rbusy  <= w_m1_rbusy_n;
            r_m1_wbusy  <= w_m1_wbusy_n;
            r_mem_addr  <= w_mem_addr_n;
            r_mem_rstrb <= w_mem_rstrb_n;
            r_mem_wdata <= w_mem_wdata_n;
            r_mem_wmask <= w_mem_wmask_n;
        end
    end

    // Request capture, access sequencing, completion and arbitration
    always_comb begin
        w_state_n     = r_state;
        w_cnt_n       = r_cnt;
        w_gnt_n       = r_gnt;
        w_last_n      = r_last;
        w_req0_n      = r_req0;
        w_req1_n      = r_req1;
        w_p1_wr_n     = r_p1_wr;
        w_p0_addr_n   = r_p0_addr;
        w_p1_addr_n   = r_p1_addr;
        w_p1_wdata_n  = r_p1_wdata;
        w_p1_wmask_n  = r_p1_wmask;
        w_m0_rdata_n  = r_m0_rdata;
        w_m1_rdata_n  = r_m1_rdata;
        w_m0_rbusy_n  = r_m0_rbusy;
        w_m1_rbusy_n  = r_m1_rbusy;
        w_m1_wbusy_n  = r_m1_wbusy;
        w_mem_addr_n  = r_mem_addr;
        w_mem_rstrb_n = 1'b0;
        w_mem_wdata_n = r_mem_wdata;
        w_mem_wmask_n = '0;
        w_free        = 1'b0;
        w_sel1        = 1'b0;

        // A write strobe wins over a simultaneous read strobe on m1
        w_acc0  = m0_rstrb & ~r_m0_rbusy;
        w_acc1w = (m1_wmask != '0) & ~(r_m1_rbusy | r_m1_wbusy);
        w_acc1r = m1_rstrb & (m1_wmask == '0) & ~(r_m1_rbusy | r_m1_wbusy);

        if (w_acc0) begin
            w_req0_n     = 1'b1;
            w_p0_addr_n  = m0_addr;
            w_m0_rbusy_n = 1'b1;
        end
        if (w_acc1w) begin
            w_req1_n     = 1'b1;
            w_p1_wr_n    = 1'b1;
            w_p1_addr_n  = m1_addr;
            w_p1_wdata_n = m1_wdata;
            w_p1_wmask_n = m1_wmask;
            w_m1_wbusy_n = 1'b1;
        end else if (w_acc1r) begin
            w_req1_n     = 1'b1;
            w_p1_wr_n    = 1'b0;
            w_p1_addr_n  = m1_addr;
            w_m1_rbusy_n = 1'b1;
        end

        case (r_state)
            S_RD: begin
                if (r_cnt == CNT_W'(RD_LATENCY)) begin
                    w_free = 1'b1;
                    if (r_gnt) begin
                        w_m1_rdata_n = mem_rdata;
                        w_m1_rbusy_n = 1'b0;
                    end else begin
                        w_m0_rdata_n = mem_rdata;
                        w_m0_rbusy_n = 1'b0;
                    end
                end else begin
                    w_cnt_n = r_cnt + CNT_W'(1);
                end
            end
            S_WR: begin
                w_free       = 1'b1;
                w_m1_wbusy_n = 1'b0;
            end
            default: w_free = 1'b1;
        endcase

        // Grant edge: issue the next access back-to-back or fall to idle
        if (w_free) begin
            w_state_n = S_IDLE;
`ifdef MEM_ARB_FIXED_PRIO_EN
            w_sel1 = w_req1_n;
`else
            w_sel1 = w_req1_n & (~w_req0_n | ~r_last);
`endif
            if (w_sel1) begin
                w_last_n     = 1'b1;
                w_gnt_n      = 1'b1;
                w_req1_n     = 1'b0;
                w_mem_addr_n = w_p1_addr_n;
                if (w_p1_wr_n) begin
                    w_state_n     = S_WR;
                    w_mem_wdata_n = w_p1_wdata_n;
                    w_mem_wmask_n = w_p1_wmask_n;
                end else begin
                    w_state_n     = S_RD;
                    w_mem_rstrb_n = 1'b1;
                    w_cnt_n       = '0;
                end
            end else if (w_req0_n) begin
                w_last_n      = 1'b0;
                w_gnt_n       = 1'b0;
                w_req0_n      = 1'b0;
                w_state_n     = S_RD;
                w_mem_addr_n  = w_p0_addr_n;
                w_mem_rstrb_n = 1'b1;
                w_cnt_n       = '0;
            end
        end
    end

    assign m0_rdata  = r_m0_rdata;
    assign m0_rbusy  = r_m0_rbusy;
    assign m1_rdata  = r_m1_rdata;
    assign m1_rbusy  = r_m1_rbusy;
    assign m1_wbusy  = r_m1_wbusy;
    assign mem_addr  = r_mem_addr;
    assign mem_rstrb = r_mem_rstrb;
    assign mem_wdata = r_mem_wdata;
    assign mem_wmask = r_mem_wmask;

endmodule
